// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Define RETIRE_CNT_EN to build the retired-instruction counter; otherwise retire_cnt is tied to 0.
//
// state  | meaning
// FETCH  | load instruction register
// DECODE | classify op/func, latch class, trap on illegal
// EXEC   | ALU controls valid; branches and jumps retire here
// MEM    | data-memory handshake with timeout
// WB     | register write-back, retire
// TRAP   | halted until reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic [4:0]  Rt,
    input  logic        mem_rdy,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        Branch,
    output logic        Jump,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWr,
    output logic        MemWr,
    output logic        ExtOp,
    output logic [4:0]  ALUctr,
    output logic        mem_req,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_ILL
    } kind_t;

    state_t      state_q, state_d;
    kind_t       dec_kind, kind_q;
    logic [4:0]  dec_alu, alu_q;
    logic        dec_src, dec_ext, dec_rtype;
    logic        src_q, ext_q, rtype_q;
    logic [1:0]  cause_q, cause_d;
    logic        mem_timeout;
    logic        unused_rt;

    // No REGIMM opcodes are in the supported subset, so rt does not affect decode.
    assign unused_rt = ^Rt;

    always_comb begin
        dec_kind  = K_ALU;
        dec_alu   = 5'd0;
        dec_src   = 1'b0;
        dec_ext   = 1'b0;
        dec_rtype = 1'b0;
        case (op)
            6'h00: begin
                dec_rtype = 1'b1;
                case (func)
                    6'h21: dec_alu = 5'd0;
                    6'h23: dec_alu = 5'd1;
                    6'h24: dec_alu = 5'd2;
                    6'h25: dec_alu = 5'd3;
                    6'h26: dec_alu = 5'd4;
                    6'h27: dec_alu = 5'd5;
                    6'h2A: dec_alu = 5'd6;
                    6'h2B: dec_alu = 5'd7;
                    6'h00: dec_alu = 5'd8;
                    6'h02: dec_alu = 5'd9;
                    6'h03: dec_alu = 5'd10;
                    6'h08: dec_kind = K_J;
                    default: dec_kind = K_ILL;
                endcase
            end
            6'h09: begin dec_alu = 5'd0;  dec_src = 1'b1; dec_ext = 1'b1; end
            6'h0A: begin dec_alu = 5'd6;  dec_src = 1'b1; dec_ext = 1'b1; end
            6'h0C: begin dec_alu = 5'd2;  dec_src = 1'b1; end
            6'h0D: begin dec_alu = 5'd3;  dec_src = 1'b1; end
            6'h0E: begin dec_alu = 5'd4;  dec_src = 1'b1; end
            6'h0F: begin dec_alu = 5'd11; dec_src = 1'b1; end
            6'h23: begin dec_kind = K_LW; dec_src = 1'b1; dec_ext = 1'b1; end
            6'h2B: begin dec_kind = K_SW; dec_src = 1'b1; dec_ext = 1'b1; end
            6'h04, 6'h05: begin dec_kind = K_BR; dec_alu = 5'd1; dec_ext = 1'b1; end
            6'h02: dec_kind = K_J;
            6'h03: dec_kind = K_JAL;
            default: dec_kind = K_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cause_q <= 2'b00;
            kind_q  <= K_ALU;
            alu_q   <= 5'd0;
            src_q   <= 1'b0;
            ext_q   <= 1'b0;
            rtype_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE) begin
                kind_q  <= dec_kind;
                alu_q   <= dec_alu;
                src_q   <= dec_src;
                ext_q   <= dec_ext;
                rtype_q <= dec_rtype;
            end
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
            logic [CW-1:0] wait_cnt;
            // wait_cnt holds the number of MEM cycles already spent before the current one.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    wait_cnt <= '0;
                else if (state_q != S_MEM)
                    wait_cnt <= '0;
                else
                    wait_cnt <= wait_cnt + 1'b1;
            end
            assign mem_timeout = (state_q == S_MEM) && (wait_cnt == CW'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign mem_timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (dec_kind == K_ILL) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (kind_q)
                    K_BR, K_J, K_JAL: state_d = S_FETCH;
                    K_LW, K_SW:       state_d = S_MEM;
                    default:          state_d = S_WB;
                endcase
            end
            S_MEM: begin
                // Completion wins over a timeout reached in the same cycle.
                if (mem_rdy) begin
                    state_d = (kind_q == K_LW) ? S_WB : S_FETCH;
                end else if (mem_timeout) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by rst so no strobe survives the reset assertion.
    always_comb begin
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        Branch   = 1'b0;
        Jump     = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        ExtOp    = 1'b0;
        ALUctr   = 5'd0;
        mem_req  = 1'b0;
        trap     = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: ir_wr = 1'b1;
                S_EXEC: begin
                    ALUctr = alu_q;
                    ALUSrc = src_q;
                    ExtOp  = ext_q;
                    Branch = (kind_q == K_BR);
                    Jump   = (kind_q == K_J) || (kind_q == K_JAL);
                    RegWr  = (kind_q == K_JAL);
                    pc_wr  = (kind_q == K_BR) || (kind_q == K_J) || (kind_q == K_JAL);
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    MemWr   = (kind_q == K_SW);
                    pc_wr   = (kind_q == K_SW) && mem_rdy;
                end
                S_WB: begin
                    RegWr    = 1'b1;
                    pc_wr    = 1'b1;
                    RegDst   = rtype_q;
                    MemtoReg = (kind_q == K_LW);
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retire_q <= 32'd0;
        else if (pc_wr)
            retire_q <= retire_q + 32'd1;
    end
    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 15).
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  Rt;
    logic        mem_rdy;
    logic        ir_wr, pc_wr, Branch, Jump, RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp;
    logic [4:0]  ALUctr;
    logic        mem_req;
    logic [2:0]  state;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] C_IR = 12'h800, C_PC = 12'h400, C_BR = 12'h200, C_JP = 12'h100;
    localparam logic [11:0] C_RD = 12'h080, C_AS = 12'h040, C_MR = 12'h020, C_RW = 12'h010;
    localparam logic [11:0] C_MW = 12'h008, C_EX = 12'h004, C_MQ = 12'h002, C_TR = 12'h001;
`ifdef RETIRE_CNT_EN
    localparam logic [31:0] EXP_RETIRE5 = 32'd5;
`else
    localparam logic [31:0] EXP_RETIRE5 = 32'd0;
`endif

    logic [11:0] ctl;
    logic [19:0] obs;
    assign ctl = {ir_wr, pc_wr, Branch, Jump, RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp, mem_req, trap};
    assign obs = {state, ctl, ALUctr};

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .Rt(Rt), .mem_rdy(mem_rdy),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .Branch(Branch), .Jump(Jump), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWr(RegWr), .MemWr(MemWr), .ExtOp(ExtOp),
        .ALUctr(ALUctr), .mem_req(mem_req), .state(state), .trap(trap),
        .trap_cause(trap_cause), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (obs !== 20'h0) begin
            errors++; $display("FAIL reset_outputs obs=%h expected=%h", obs, 20'h0);
        end
        checks++;
        if (trap_cause !== 2'd0 || retire_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_regs cause=%0d retire=%0d expected 0 0", trap_cause, retire_cnt);
        end
        cyc();
        checks++;
        if (obs !== 20'h0) begin
            errors++; $display("FAIL reset_held obs=%h expected=%h", obs, 20'h0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {3'd0, C_IR, 5'd0}) begin
            errors++; $display("FAIL reset_release obs=%h expected=%h", obs, {3'd0, C_IR, 5'd0});
        end
    endtask

    task automatic test_alu_ops;
        logic [5:0]  o, f;
        logic [4:0]  ea;
        logic [11:0] ee, ew;
        for (int i = 0; i < 9; i++) begin
            o = 6'h00; f = 6'h21; ea = 5'd0; ee = 12'h0; ew = C_PC | C_RW | C_RD;
            case (i)
                1: begin f = 6'h23; ea = 5'd1; end
                2: begin f = 6'h2A; ea = 5'd6; end
                3: begin f = 6'h03; ea = 5'd10; end
                4: begin o = 6'h0D; ea = 5'd3;  ee = C_AS;        ew = C_PC | C_RW; end
                5: begin o = 6'h09; ea = 5'd0;  ee = C_AS | C_EX; ew = C_PC | C_RW; end
                6: begin o = 6'h0F; ea = 5'd11; ee = C_AS;        ew = C_PC | C_RW; end
                7: begin o = 6'h0A; ea = 5'd6;  ee = C_AS | C_EX; ew = C_PC | C_RW; end
                8: begin f = 6'h27; ea = 5'd5; end
                default: ;
            endcase
            op = o; func = f;
            #1;
            checks++;
            if (obs !== {3'd0, C_IR, 5'd0}) begin
                errors++; $display("FAIL alu%0d_fetch obs=%h expected=%h", i, obs, {3'd0, C_IR, 5'd0});
            end
            cyc();
            checks++;
            if (obs !== {3'd1, 12'h0, 5'd0}) begin
                errors++; $display("FAIL alu%0d_decode obs=%h expected=%h", i, obs, {3'd1, 12'h0, 5'd0});
            end
            cyc();
            checks++;
            if (obs !== {3'd2, ee, ea}) begin
                errors++; $display("FAIL alu%0d_exec obs=%h expected=%h", i, obs, {3'd2, ee, ea});
            end
            cyc();
            checks++;
            if (obs !== {3'd4, ew, 5'd0}) begin
                errors++; $display("FAIL alu%0d_wb obs=%h expected=%h", i, obs, {3'd4, ew, 5'd0});
            end
            cyc();
        end
    endtask

    task automatic test_branch_jump;
        logic [5:0]  o, f;
        logic [4:0]  ea;
        logic [11:0] ee;
        for (int i = 0; i < 5; i++) begin
            o = 6'h04; f = 6'h00; ea = 5'd1; ee = C_BR | C_PC | C_EX;
            case (i)
                1: o = 6'h05;
                2: begin o = 6'h02; ea = 5'd0; ee = C_JP | C_PC; end
                3: begin o = 6'h03; ea = 5'd0; ee = C_JP | C_PC | C_RW; end
                4: begin o = 6'h00; f = 6'h08; ea = 5'd0; ee = C_JP | C_PC; end
                default: ;
            endcase
            op = o; func = f;
            cyc();
            cyc();
            checks++;
            if (obs !== {3'd2, ee, ea}) begin
                errors++; $display("FAIL bj%0d_exec obs=%h expected=%h", i, obs, {3'd2, ee, ea});
            end
            cyc();
            checks++;
            if (obs !== {3'd0, C_IR, 5'd0}) begin
                errors++; $display("FAIL bj%0d_refetch obs=%h expected=%h", i, obs, {3'd0, C_IR, 5'd0});
            end
        end
    endtask

    task automatic test_lw_wait;
        op = 6'h23; func = 6'h00; mem_rdy = 1'b0;
        cyc();
        cyc();
        checks++;
        if (obs !== {3'd2, C_AS | C_EX, 5'd0}) begin
            errors++; $display("FAIL lw_exec obs=%h expected=%h", obs, {3'd2, C_AS | C_EX, 5'd0});
        end
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_rdy = 1'b1;
            #1;
            checks++;
            if (obs !== {3'd3, C_MQ, 5'd0}) begin
                errors++; $display("FAIL lw_mem%0d obs=%h expected=%h", i, obs, {3'd3, C_MQ, 5'd0});
            end
            cyc();
        end
        mem_rdy = 1'b0;
        #1;
        checks++;
        if (obs !== {3'd4, C_PC | C_RW | C_MR, 5'd0}) begin
            errors++; $display("FAIL lw_wb obs=%h expected=%h", obs, {3'd4, C_PC | C_RW | C_MR, 5'd0});
        end
        cyc();
        checks++;
        if (obs !== {3'd0, C_IR, 5'd0}) begin
            errors++; $display("FAIL lw_refetch obs=%h expected=%h", obs, {3'd0, C_IR, 5'd0});
        end
    endtask

    task automatic test_sw_ready;
        op = 6'h2B; func = 6'h00;
        cyc();
        cyc();
        cyc();
        mem_rdy = 1'b1;
        #1;
        checks++;
        if (obs !== {3'd3, C_MQ | C_MW | C_PC, 5'd0}) begin
            errors++; $display("FAIL sw_mem obs=%h expected=%h", obs, {3'd3, C_MQ | C_MW | C_PC, 5'd0});
        end
        cyc();
        mem_rdy = 1'b0;
        #1;
        checks++;
        if (obs !== {3'd0, C_IR, 5'd0}) begin
            errors++; $display("FAIL sw_refetch obs=%h expected=%h", obs, {3'd0, C_IR, 5'd0});
        end
    endtask

    task automatic test_timeout_boundary;
        op = 6'h23; func = 6'h00; mem_rdy = 1'b0;
        cyc();
        cyc();
        cyc();
        for (int i = 0; i < 15; i++) begin
            if (i == 14) mem_rdy = 1'b1;
            #1;
            if (i == 14) begin
                checks++;
                if (obs !== {3'd3, C_MQ, 5'd0}) begin
                    errors++; $display("FAIL bound_mem15 obs=%h expected=%h", obs, {3'd3, C_MQ, 5'd0});
                end
            end
            cyc();
        end
        mem_rdy = 1'b0;
        #1;
        checks++;
        if (obs !== {3'd4, C_PC | C_RW | C_MR, 5'd0}) begin
            errors++; $display("FAIL bound_wb obs=%h expected=%h", obs, {3'd4, C_PC | C_RW | C_MR, 5'd0});
        end
        cyc();
    endtask

    task automatic test_sw_timeout;
        op = 6'h2B; func = 6'h00; mem_rdy = 1'b0;
        cyc();
        cyc();
        cyc();
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (obs !== {3'd3, C_MQ | C_MW, 5'd0}) begin
                errors++; $display("FAIL swto_mem%0d obs=%h expected=%h", i, obs, {3'd3, C_MQ | C_MW, 5'd0});
            end
            cyc();
        end
        checks++;
        if (obs !== {3'd7, C_TR, 5'd0} || trap_cause !== 2'b10) begin
            errors++; $display("FAIL swto_trap obs=%h cause=%0d expected=%h cause=2", obs, trap_cause, {3'd7, C_TR, 5'd0});
        end
        do_reset();
    endtask

    task automatic test_illegal;
        op = 6'h3F; func = 6'h00;
        #1;
        cyc();
        checks++;
        if (obs !== {3'd1, 12'h0, 5'd0}) begin
            errors++; $display("FAIL ill_decode obs=%h expected=%h", obs, {3'd1, 12'h0, 5'd0});
        end
        cyc();
        checks++;
        if (obs !== {3'd7, C_TR, 5'd0} || trap_cause !== 2'b01) begin
            errors++; $display("FAIL ill_trap obs=%h cause=%0d expected=%h cause=1", obs, trap_cause, {3'd7, C_TR, 5'd0});
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (obs !== {3'd7, C_TR, 5'd0} || trap_cause !== 2'b01) begin
                errors++; $display("FAIL ill_hold%0d obs=%h cause=%0d expected=%h cause=1", i, obs, trap_cause, {3'd7, C_TR, 5'd0});
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 20'h0 || trap_cause !== 2'b00) begin
            errors++; $display("FAIL ill_rst obs=%h cause=%0d expected=0 cause=0", obs, trap_cause);
        end
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {3'd0, C_IR, 5'd0}) begin
            errors++; $display("FAIL ill_release obs=%h expected=%h", obs, {3'd0, C_IR, 5'd0});
        end
        op = 6'h00; func = 6'h3F;
        cyc();
        cyc();
        checks++;
        if (obs !== {3'd7, C_TR, 5'd0} || trap_cause !== 2'b01) begin
            errors++; $display("FAIL ill_func obs=%h cause=%0d expected=%h cause=1", obs, trap_cause, {3'd7, C_TR, 5'd0});
        end
        do_reset();
    endtask

    task automatic test_retire_and_reset;
        op = 6'h00; func = 6'h21;
        for (int i = 0; i < 20; i++) cyc();
        checks++;
        if (retire_cnt !== EXP_RETIRE5 || state !== 3'd0) begin
            errors++; $display("FAIL retire5 cnt=%0d state=%0d expected cnt=%0d state=0", retire_cnt, state, EXP_RETIRE5);
        end
        op = 6'h23; mem_rdy = 1'b0;
        cyc();
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 20'h0 || retire_cnt !== 32'd0 || trap_cause !== 2'd0) begin
            errors++; $display("FAIL midmem_rst obs=%h cnt=%0d cause=%0d expected all 0", obs, retire_cnt, trap_cause);
        end
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {3'd0, C_IR, 5'd0}) begin
            errors++; $display("FAIL midmem_release obs=%h expected=%h", obs, {3'd0, C_IR, 5'd0});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; op = 6'h00; func = 6'h21; Rt = 5'd0; mem_rdy = 1'b0;
        test_reset();
        test_alu_ops();
        test_branch_jump();
        test_lw_wait();
        test_sw_ready();
        test_timeout_boundary();
        test_sw_timeout();
        test_illegal();
        test_retire_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
